// File: rtl/two_to_one_mux.sv
// two_to_one_mux: width-parameterised 2:1 word select.
// REGISTERED=1 builds a one-cycle pipeline stage with load enable and valid
// flag. REGISTERED=0 builds a zero-latency combinational mux.
module two_to_one_mux #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned REGISTERED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             sel_q
);

    logic [WIDTH-1:0] out_d;

    // Word selection shared by both build options: sel=0 -> a, sel=1 -> b.
    always_comb begin
        out_d = a;
        if (sel) begin
            out_d = b;
        end
    end

    if (REGISTERED != 0) begin : g_reg

        logic [WIDTH-1:0] out_q;
        logic             sel_hold_q;
        logic             valid_q;

        // Capture the selected word on enabled edges; valid marks the cycle after.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q      <= '0;
                sel_hold_q <= 1'b0;
                valid_q    <= 1'b0;
            end else begin
                valid_q <= en;
                if (en) begin
                    out_q      <= out_d;
                    sel_hold_q <= sel;
                end
            end
        end

        assign out       = out_q;
        assign sel_q     = sel_hold_q;
        assign out_valid = valid_q;

    end else begin : g_comb

        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign out       = out_d;
        assign sel_q     = sel;
        assign out_valid = en;

    end

endmodule

// File: tb/tb_two_to_one_mux.sv
// Directed bench for two_to_one_mux: registered 4-bit, combinational 4-bit
// and registered 8-bit builds.
module tb_two_to_one_mux;

    logic clk;
    logic rst_n;

    // Registered 4-bit instance
    logic [3:0] a, b, out;
    logic       sel, en, out_valid, sel_q;

    // Combinational 4-bit instance
    logic [3:0] ca, cb, c_out;
    logic       csel, cen, c_valid, c_sel_q;

    // Registered 8-bit instance
    logic [7:0] wa, wb, w_out;
    logic       wsel, wen, w_valid, w_sel_q;

    int total;
    int passed;

    two_to_one_mux #(.WIDTH(4), .REGISTERED(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .en(en),
        .out(out), .out_valid(out_valid), .sel_q(sel_q)
    );

    two_to_one_mux #(.WIDTH(4), .REGISTERED(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .a(ca), .b(cb), .sel(csel), .en(cen),
        .out(c_out), .out_valid(c_valid), .sel_q(c_sel_q)
    );

    two_to_one_mux #(.WIDTH(8), .REGISTERED(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(wa), .b(wb), .sel(wsel), .en(wen),
        .out(w_out), .out_valid(w_valid), .sel_q(w_sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one vector on the falling edge, then check 1 time unit after the rising edge.
    task automatic step(input logic [3:0] ai, input logic [3:0] bi, input logic si,
                        input logic ei, input logic [3:0] exp_out,
                        input logic exp_valid, input logic exp_sel, input string tag);
        @(negedge clk);
        a = ai; b = bi; sel = si; en = ei;
        @(posedge clk);
        #1;
        chk({tag, ".out"}, {4'd0, out}, {4'd0, exp_out});
        chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, exp_valid});
        chk({tag, ".sel_q"}, {7'd0, sel_q}, {7'd0, exp_sel});
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        a = 4'd13; b = 4'd11; sel = 1'b0; en = 1'b1;
        ca = '0; cb = '0; csel = 1'b0; cen = 1'b0;
        wa = '0; wb = '0; wsel = 1'b0; wen = 1'b0;

        // Reset state before any clock edge
        #1;
        chk("rst.out", {4'd0, out}, 8'd0);
        chk("rst.valid", {7'd0, out_valid}, 8'd0);
        chk("rst.sel_q", {7'd0, sel_q}, 8'd0);

        // Edge with reset held low captures nothing
        @(posedge clk);
        #1;
        chk("rst_edge.out", {4'd0, out}, 8'd0);
        chk("rst_edge.valid", {7'd0, out_valid}, 8'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Streaming sequence, one pair per cycle
        step(4'd13, 4'd11, 1'b0, 1'b1, 4'd13, 1'b1, 1'b0, "s0");
        step(4'd3,  4'd11, 1'b1, 1'b1, 4'd11, 1'b1, 1'b1, "s1");
        step(4'd11, 4'd11, 1'b0, 1'b1, 4'd11, 1'b1, 1'b0, "s2");
        step(4'd3,  4'd1,  1'b1, 1'b1, 4'd1,  1'b1, 1'b1, "s3");
        step(4'd10, 4'd11, 1'b1, 1'b1, 4'd11, 1'b1, 1'b1, "s4");

        // Input changes between edges do not reach out
        @(negedge clk);
        a = 4'd0; b = 4'd6; sel = 1'b0;
        #1;
        chk("mid.out", {4'd0, out}, 8'd11);
        chk("mid.sel_q", {7'd0, sel_q}, 8'd1);

        // Equal inputs with sel=1
        step(4'd7, 4'd7, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, "eq1");

        // Mid-stream reset pulse between edges clears immediately
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.out", {4'd0, out}, 8'd0);
        chk("mrst.valid", {7'd0, out_valid}, 8'd0);
        chk("mrst.sel_q", {7'd0, sel_q}, 8'd0);
        #1;
        rst_n = 1'b1;

        step(4'd12, 4'd7, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0, "after_rst");

        // Hold with en=0
        step(4'd3, 4'd11, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, "cap3");
        step(4'd9, 4'd5,  1'b1, 1'b0, 4'd3, 1'b0, 1'b0, "hold1");
        step(4'd9, 4'd5,  1'b1, 1'b0, 4'd3, 1'b0, 1'b0, "hold2");
        step(4'd9, 4'd5,  1'b1, 1'b1, 4'd5, 1'b1, 1'b1, "reen");

        // Combinational build: no clock dependency
        ca = 4'd10; cb = 4'd11; csel = 1'b0; cen = 1'b1;
        #1;
        chk("comb.out0", {4'd0, c_out}, 8'd10);
        chk("comb.sel0", {7'd0, c_sel_q}, 8'd0);
        chk("comb.valid1", {7'd0, c_valid}, 8'd1);
        csel = 1'b1;
        #1;
        chk("comb.out1", {4'd0, c_out}, 8'd11);
        chk("comb.sel1", {7'd0, c_sel_q}, 8'd1);
        cen = 1'b0;
        #1;
        chk("comb.valid0", {7'd0, c_valid}, 8'd0);
        ca = 4'd4; cb = 4'd4; csel = 1'b0;
        #1;
        chk("comb.eq", {4'd0, c_out}, 8'd4);

        // 8-bit registered build
        @(negedge clk);
        wa = 8'hA5; wb = 8'h5A; wsel = 1'b1; wen = 1'b1;
        @(posedge clk);
        #1;
        chk("w8.out_b", w_out, 8'h5A);
        chk("w8.sel1", {7'd0, w_sel_q}, 8'd1);
        chk("w8.valid", {7'd0, w_valid}, 8'd1);
        @(negedge clk);
        wsel = 1'b0;
        @(posedge clk);
        #1;
        chk("w8.out_a", w_out, 8'hA5);
        chk("w8.sel0", {7'd0, w_sel_q}, 8'd0);
        @(negedge clk);
        wen = 1'b0; wsel = 1'b1;
        @(posedge clk);
        #1;
        chk("w8.hold", w_out, 8'hA5);
        chk("w8.valid0", {7'd0, w_valid}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/two_to_one_mux.md
# two_to_one_mux

Width-parameterised 2:1 multiplexer that selects one of two data words (`a` or `b`) under control of `sel`. By default the selected word is registered on the system clock with a load enable and a valid flag, so the block drops into a clocked datapath as a one-cycle pipeline stage. A combinational build option gives a zero-latency mux for glue-logic use. Typical use is 4-bit operand or result steering in small arithmetic datapaths.

## Interface

Clocking is fixed: one clock; reset is asynchronous and active-low.

Parameters:
- `WIDTH`, default 4: data width of `a`, `b` and `out`; legal range is 1 or more.
- `REGISTERED`, default 1: 1 selects the registered output stage; 0 selects a purely combinational mux.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a`  input  WIDTH  data input 0, selected when `sel`=0.
- `b`  input  WIDTH  data input 1, selected when `sel`=1.
- `sel`  input  1  select line.
- `en`  input  1  load enable; the output register captures only when this is 1.
- `out`  output  WIDTH  selected data.
- `out_valid`  output  1  high when `out` holds data captured on the previous enabled edge.
- `sel_q`  output  1  value of `sel` that produced the current `out`.

## Operation

- Selection function: `sel`=0 gives `a`, `sel`=1 gives `b`. The selected bits are passed through unchanged, with no width change and no arithmetic.
- `REGISTERED`=1:
  - On a rising edge of `clk` with `en`=1: `out` <= (`sel` ? `b` : `a`), `sel_q` <= `sel`, `out_valid` <= 1.
  - On a rising edge with `en`=0: `out` and `sel_q` hold their values, and `out_valid` <= 0.
  - While `rst_n`=0, regardless of `clk`: `out`=0, `sel_q`=0, `out_valid`=0.
- `REGISTERED`=0:
  - `out` = (`sel` ? `b` : `a`) and `sel_q` = `sel`, both combinational.
  - `out_valid` = `en`, combinational.
  - `clk` and `rst_n` are ignored and no state exists.
- `a` = `b`: `out` equals the common value for either `sel`.
- No handshake beyond `en`/`out_valid`. There is no backpressure; downstream must consume `out` in the cycle `out_valid`=1, or rely on the held value.

## Timing

- `REGISTERED`=1:
  - Latency is 1 cycle: inputs sampled at edge N appear on `out` after edge N, and `out_valid`=1 for exactly the cycles following enabled edges.
  - Back-to-back enabled cycles give throughput of 1 word per clock.
  - Inputs must meet setup/hold to `clk`. Changes to `a`, `b` or `sel` between edges have no effect on `out`.
- Reset:
  - Assertion clears all outputs immediately, without waiting for a clock edge.
  - Deassertion is synchronised externally. The first capture happens on the first rising edge with `rst_n`=1 and `en`=1.
  - Reset asserted mid-stream discards the held word.
  - An edge that coincides with `rst_n`=0 captures nothing; reset wins.
- `REGISTERED`=0: `out` follows the inputs after combinational delay only, with zero cycles of latency.

## Test plan

- Reset: drive `rst_n`=0 with `a`=13, `b`=11, `en`=1 -> `out`=0, `out_valid`=0, `sel_q`=0. Outputs clear immediately, before any clock edge.
- Selection sequence with `REGISTERED`=1, `en`=1, one pair per cycle: (13,11,sel 0), (3,11,1), (11,11,0), (3,1,1), (10,11,1), (12,7,0) -> `out` = 13, 11, 11, 1, 11, 12, each appearing one cycle later, with `out_valid`=1 throughout and `sel_q` tracking `sel`.
- Hold: capture `a`=3, `sel`=0 (`out`=3), then set `en`=0 and change to `a`=9, `b`=5, `sel`=1 -> `out` stays 3, `sel_q` stays 0, `out_valid`=0.
- Mid-operation reset: during the streaming sequence, pulse `rst_n` low between edges -> `out` goes to 0 asynchronously. After release, the next enabled edge with `a`=12, `b`=7, `sel`=0 gives `out`=12.
- Combinational build (`REGISTERED`=0): `a`=10, `b`=11, toggle `sel` 0->1 with no clock -> `out` changes 10->11 immediately, and `out_valid` follows `en`.
- Width check (`WIDTH`=8): `a`=8'hA5, `b`=8'h5A, `sel`=1 -> `out`=8'h5A; with `sel`=0 -> `out`=8'hA5.
